// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle CPU control path: FSM states, opcodes,
// ALU operation classes and the packed control word driven to the datapath.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_RTYPE = 3'b010;
    localparam logic [2:0] ALUOP_SLT   = 3'b011;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic       pc_src;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src;
        logic [2:0] alu_op;
        logic       illegal;
        logic       halted;
    } ctrl_word_t;

    // Opcodes that DECODE accepts, HALT included.
    function automatic logic is_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_SLTI) ||
               (op == OP_BEQ)   || (op == OP_LW)   || (op == OP_SW)   ||
               (op == OP_HALT);
    endfunction

endpackage

// File: rtl/ctrl_out_decode.sv
// Combinational control-word table: current state plus opcode (and, in a few
// phases, zero flag / memory ready) to the datapath enables and mux selects.
module ctrl_out_decode
    import cpu_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output ctrl_word_t cw
);

    always_comb begin
        cw = '0;
        case (state)
            S_FETCH: begin
                cw.mem_req  = 1'b1;
                cw.ir_write = mem_ready;
                cw.pc_write = mem_ready;
            end
            S_DECODE: begin
                cw.illegal = !is_supported(opcode);
            end
            S_EXEC: begin
                case (opcode)
                    OP_RTYPE: cw.alu_op = ALUOP_RTYPE;
                    OP_SLTI:  cw.alu_op = ALUOP_SLT;
                    OP_BEQ:   cw.alu_op = ALUOP_SUB;
                    default:  cw.alu_op = ALUOP_ADD;
                endcase
                cw.alu_src = (opcode == OP_ADDI) || (opcode == OP_SLTI) ||
                             (opcode == OP_LW)   || (opcode == OP_SW);
                // Taken branch overwrites the PC+4 loaded during FETCH.
                if (opcode == OP_BEQ) begin
                    cw.pc_write = zero;
                    cw.pc_src   = zero;
                end
            end
            S_MEM: begin
                cw.mem_req = 1'b1;
                cw.i_or_d  = 1'b1;
                cw.mem_we  = (opcode == OP_SW);
            end
            S_WB: begin
                cw.reg_write  = 1'b1;
                cw.reg_dst    = (opcode == OP_RTYPE);
                cw.mem_to_reg = (opcode == OP_LW);
            end
            S_HALT: begin
                cw.halted = 1'b1;
            end
            default: begin
                cw = '0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: sequences FETCH/DECODE/EXEC/MEM/WB over one shared
// datapath, handshakes the shared memory port and counts retired instructions.
module multicycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int ALUOP_W = 3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [5:0]         opcode_i,
    input  logic               zero_i,
    input  logic               mem_ready_i,
    output logic               mem_req_o,
    output logic               mem_we_o,
    output logic               i_or_d_o,
    output logic               ir_write_o,
    output logic               pc_write_o,
    output logic               pc_src_o,
    output logic               reg_write_o,
    output logic               reg_dst_o,
    output logic               mem_to_reg_o,
    output logic               alu_src_o,
    output logic [ALUOP_W-1:0] alu_op_o,
    output logic               illegal_o,
    output logic               halted_o,
    output logic [2:0]         state_o,
    output logic [CNT_W-1:0]   retired_o
);

    // Memory handshake: mem_req_o (with i_or_d_o / mem_we_o) stays asserted and
    // stable until a cycle in which mem_ready_i is high; the access completes on
    // that rising edge and the FSM leaves FETCH/MEM. ready is ignored elsewhere.

    state_t           state_q, state_d;
    logic             retire;
    logic [CNT_W-1:0] retired_q;
    ctrl_word_t       cw, cw_out;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (mem_ready_i) state_d = S_DECODE;
            end
            S_DECODE: begin
                case (opcode_i)
                    OP_RTYPE, OP_ADDI, OP_SLTI,
                    OP_BEQ, OP_LW, OP_SW:      state_d = S_EXEC;
                    OP_HALT:                   state_d = S_HALT;
                    default:                   state_d = S_FETCH;
                endcase
            end
            S_EXEC: begin
                case (opcode_i)
                    OP_BEQ: begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    OP_LW, OP_SW:              state_d = S_MEM;
                    OP_RTYPE, OP_ADDI, OP_SLTI: state_d = S_WB;
                    default:                   state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (mem_ready_i) begin
                    if (opcode_i == OP_SW) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    ctrl_out_decode u_decode (
        .state     (state_q),
        .opcode    (opcode_i),
        .zero      (zero_i),
        .mem_ready (mem_ready_i),
        .cw        (cw)
    );

    // While reset is held every control output is forced quiet, so an access
    // in flight is abandoned immediately rather than re-requested from FETCH.
    assign cw_out = rst_i ? cw : '0;

    assign mem_req_o    = cw_out.mem_req;
    assign mem_we_o     = cw_out.mem_we;
    assign i_or_d_o     = cw_out.i_or_d;
    assign ir_write_o   = cw_out.ir_write;
    assign pc_write_o   = cw_out.pc_write;
    assign pc_src_o     = cw_out.pc_src;
    assign reg_write_o  = cw_out.reg_write;
    assign reg_dst_o    = cw_out.reg_dst;
    assign mem_to_reg_o = cw_out.mem_to_reg;
    assign alu_src_o    = cw_out.alu_src;
    assign alu_op_o     = ALUOP_W'(cw_out.alu_op);
    assign illegal_o    = cw_out.illegal;
    assign halted_o     = cw_out.halted;
    assign state_o      = state_q;
    assign retired_o    = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction phase plans built
// from the instruction latency rules, checked cycle by cycle via a scoreboard.
module tb_multicycle_ctrl;

    localparam int CNT_W = 4;
    localparam int W     = 15;

    localparam int ST_FETCH = 0, ST_DECODE = 1, ST_EXEC = 2, ST_MEM = 3, ST_WB = 4, ST_HALT = 5;

    localparam logic [5:0] R_OP = 6'b000000, ADDI = 6'b001000, SLTI = 6'b001010;
    localparam logic [5:0] BEQ = 6'b000100, LW = 6'b100011, SW = 6'b101011, HALT = 6'b111111;

    logic             clk = 1'b0;
    logic             rst_i, zero_i, mem_ready_i;
    logic [5:0]       opcode_i;
    logic             mem_req_o, mem_we_o, i_or_d_o, ir_write_o, pc_write_o, pc_src_o;
    logic             reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_o, illegal_o, halted_o;
    logic [2:0]       alu_op_o, state_o;
    logic [CNT_W-1:0] retired_o;
    logic [W-1:0]     act_word;

    int checks = 0;
    int errors = 0;
    int exp_ret = 0;

    logic [W-1:0] exp_q[$];
    int           st_q[$];
    logic         rdy_q[$];
    logic         zero_q[$];

    multicycle_ctrl #(.CNT_W(CNT_W), .ALUOP_W(3)) dut (
        .clk_i(clk), .rst_i(rst_i), .opcode_i(opcode_i), .zero_i(zero_i),
        .mem_ready_i(mem_ready_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .i_or_d_o(i_or_d_o), .ir_write_o(ir_write_o), .pc_write_o(pc_write_o),
        .pc_src_o(pc_src_o), .reg_write_o(reg_write_o), .reg_dst_o(reg_dst_o),
        .mem_to_reg_o(mem_to_reg_o), .alu_src_o(alu_src_o), .alu_op_o(alu_op_o),
        .illegal_o(illegal_o), .halted_o(halted_o), .state_o(state_o),
        .retired_o(retired_o)
    );

    always #5 clk = ~clk;

    assign act_word = {mem_req_o, mem_we_o, i_or_d_o, ir_write_o, pc_write_o, pc_src_o,
                       reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_o, alu_op_o,
                       illegal_o, halted_o};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected control word for one cycle, straight from the per-phase rules.
    function automatic logic [W-1:0] model_word(input int st, input logic [5:0] op,
                                                input logic z, input logic rdy);
        logic req, we, iod, irw, pcw, pcs, rw, rd, m2r, asrc, ill, hlt;
        logic [2:0] aop;
        {req, we, iod, irw, pcw, pcs, rw, rd, m2r, asrc, ill, hlt} = '0;
        aop = 3'b000;
        case (st)
            ST_FETCH:  begin req = 1'b1; irw = rdy; pcw = rdy; end
            ST_DECODE: ill = !(op inside {R_OP, ADDI, SLTI, BEQ, LW, SW, HALT});
            ST_EXEC: begin
                if (op == R_OP)      aop = 3'b010;
                else if (op == SLTI) aop = 3'b011;
                else if (op == BEQ)  aop = 3'b001;
                asrc = op inside {ADDI, SLTI, LW, SW};
                if (op == BEQ) begin pcw = z; pcs = z; end
            end
            ST_MEM:  begin req = 1'b1; iod = 1'b1; we = (op == SW); end
            ST_WB:   begin rw = 1'b1; rd = (op == R_OP); m2r = (op == LW); end
            ST_HALT: hlt = 1'b1;
            default: ;
        endcase
        return {req, we, iod, irw, pcw, pcs, rw, rd, m2r, asrc, aop, ill, hlt};
    endfunction

    task automatic push_cycle(input int st, input logic rdy, input logic z, input logic [5:0] op);
        st_q.push_back(st);
        rdy_q.push_back(rdy);
        zero_q.push_back(z);
        exp_q.push_back(model_word(st, op, z, rdy));
    endtask

    // Phase plan: fw/mw are wait cycles in FETCH/MEM; zero only matters in EXEC.
    task automatic plan_instr(input logic [5:0] op, input logic z, input int fw, input int mw,
                              output int retires);
        retires = 0;
        for (int i = 0; i <= fw; i++) push_cycle(ST_FETCH, i == fw, 1'($urandom_range(0, 1)), op);
        push_cycle(ST_DECODE, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), op);
        if (op == HALT) begin
            for (int i = 0; i < 4; i++)
                push_cycle(ST_HALT, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), op);
            return;
        end
        if (!(op inside {R_OP, ADDI, SLTI, BEQ, LW, SW})) return;
        push_cycle(ST_EXEC, 1'($urandom_range(0, 1)), z, op);
        retires = 1;
        if (op == BEQ) return;
        if (op inside {LW, SW}) begin
            for (int i = 0; i <= mw; i++) push_cycle(ST_MEM, i == mw, 1'($urandom_range(0, 1)), op);
            if (op == SW) return;
        end
        push_cycle(ST_WB, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), op);
    endtask

    // Drives one instruction; abort_at >= 0 stops before that cycle index.
    task automatic run_instr(input logic [5:0] op, input logic z, input int fw, input int mw,
                             input int abort_at);
        int retires, n, st;
        logic [W-1:0] exp_w;
        plan_instr(op, z, fw, mw, retires);
        n = st_q.size();
        for (int c = 0; c < n; c++) begin
            if (abort_at >= 0 && c == abort_at) begin
                exp_q.delete(); st_q.delete(); rdy_q.delete(); zero_q.delete();
                return;
            end
            @(negedge clk);
            rst_i       = 1'b1;
            opcode_i    = op;
            mem_ready_i = rdy_q.pop_front();
            zero_i      = zero_q.pop_front();
            #1;
            st    = st_q.pop_front();
            exp_w = exp_q.pop_front();
            check_eq($sformatf("state op=%b c=%0d", op, c), 32'(state_o), 32'(st));
            check_eq($sformatf("ctrl op=%b c=%0d", op, c), 32'(act_word), 32'(exp_w));
            check_eq($sformatf("retired op=%b c=%0d", op, c), 32'(retired_o), 32'(exp_ret));
        end
        exp_ret = (exp_ret + retires) % (1 << CNT_W);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_i       = 1'b0;
        mem_ready_i = 1'b1;
        #1;
        check_eq("reset_outputs_quiet", 32'(act_word), 32'(0));
        @(negedge clk);
        #1;
        check_eq("reset_state", 32'(state_o), 32'(ST_FETCH));
        check_eq("reset_outputs", 32'(act_word), 32'(0));
        check_eq("reset_retired", 32'(retired_o), 32'(0));
        exp_ret = 0;
    endtask

    initial begin
        logic [5:0] op;
        rst_i = 1'b0; opcode_i = '0; zero_i = 1'b0; mem_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("init_state", 32'(state_o), 32'(ST_FETCH));
        check_eq("init_outputs", 32'(act_word), 32'(0));
        check_eq("init_retired", 32'(retired_o), 32'(0));

        run_instr(R_OP, 1'b0, 0, 0, -1);
        check_eq("first_R_retired", 32'(exp_ret), 32'(1));
        run_instr(LW,   1'b0, 0, 2, -1);
        run_instr(BEQ,  1'b1, 0, 0, -1);
        run_instr(BEQ,  1'b0, 0, 0, -1);
        run_instr(6'b010101, 1'b0, 0, 0, -1);
        run_instr(SW,   1'b0, 1, 1, -1);

        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 7))
                0: op = R_OP;
                1: op = ADDI;
                2: op = SLTI;
                3: op = BEQ;
                4: op = LW;
                5: op = SW;
                6: op = 6'($urandom_range(0, 62));
                default: op = R_OP;
            endcase
            run_instr(op, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 2), -1);
        end

        // sw stalled in MEM: cycles F,D,E,M(wait) run, reset lands on the second MEM cycle
        run_instr(SW, 1'b0, 0, 3, 4);
        do_reset();
        run_instr(ADDI, 1'b0, 0, 0, -1);

        run_instr(HALT, 1'b0, 0, 0, -1);
        do_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
